// File: rtl/pwm_output_driver_pkg.sv
// Shared types and constants for the PWM output driver: counter limits, the
// channel mask type and the per-tick compare rule.
package pwm_pkg;
  localparam int           CNT_W     = 8;
  localparam logic [7:0]   CNT_MAX   = 8'd254;
  localparam logic [7:0]   DUTY_FULL = 8'hFF;
  localparam int           NUM_CH    = 16;

  typedef logic [NUM_CH-1:0] ch_mask_t;

  // Full-scale duty forces a solid high so there is no low tick at the wrap.
  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction
endpackage

// File: rtl/pwm_output_driver_if.sv
// Register-block side and pin side of the PWM output driver.
interface pwm_output_driver_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_output_driver_prescaler.sv
// Free-running clock divider: one-cycle tick every PRESCALE clocks.
module pwm_prescaler #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pcnt;

  // With PRESCALE=1 pcnt stays at 0 and tick is permanently high.
  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst)       pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end
endmodule

// File: rtl/pwm_output_driver.sv
// Drives 16 pins as static levels or a shared 8-bit PWM; the duty value is
// shadowed so it only changes at period boundaries.
module pwm_output_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_output_driver_if.slave   bus
);
  ch_mask_t         en_out, en_pwm, out_nxt, out_q;
  logic             tick, wrap, wrap_d, lvl, ps_q;
  logic [CNT_W-1:0] cnt, duty_sh;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap = tick && (cnt == CNT_MAX);

  // wrap_d marks the first cycle at cnt=0 of a new period; the output stage
  // turns it into period_start one clock later, aligned with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      duty_sh <= '0;
      wrap_d  <= 1'b0;
    end else begin
      if (tick)  cnt     <= wrap ? '0 : cnt + 1'b1;
      if (wrap)  duty_sh <= bus.pwm_duty_cycle;
      wrap_d <= wrap;
    end
  end

  assign lvl = pwm_level(cnt, duty_sh);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign out_nxt[i] = en_out[i] & (en_pwm[i] ? lvl : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      out_q <= out_nxt;
      ps_q  <= wrap_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_output_driver.sv
// Randomized and directed bench for pwm_output_driver with PRESCALE=1 and 13
// instances driven in parallel against an arithmetic reference model.
module tb_pwm_output_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_output_driver_if bus1 ();
  pwm_output_driver_if bus13 ();

  pwm_output_driver #(.PRESCALE(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  pwm_output_driver #(.PRESCALE(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

  // Model state: n = clocks since reset, dsh = duty in force this period.
  int         pre[2] = '{1, 13};
  int         n[2]   = '{0, 0};
  logic [7:0] dsh[2] = '{8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {bus1.en_reg_out_15_8, bus1.en_reg_out_7_0}   = eo;
    {bus1.en_reg_pwm_15_8, bus1.en_reg_pwm_7_0}   = ep;
    bus1.pwm_duty_cycle = d;
    {bus13.en_reg_out_15_8, bus13.en_reg_out_7_0} = eo;
    {bus13.en_reg_pwm_15_8, bus13.en_reg_pwm_7_0} = ep;
    bus13.pwm_duty_cycle = d;
  endtask

  // Predict from inputs held across the coming edge, clock, then compare.
  task automatic step(input int cycles = 1);
    logic [15:0] eo[2];
    logic        ep[2];
    logic [15:0] en_o, en_p;
    int          per, c;
    logic        lvl;
    repeat (cycles) begin
      en_o = {bus1.en_reg_out_15_8, bus1.en_reg_out_7_0};
      en_p = {bus1.en_reg_pwm_15_8, bus1.en_reg_pwm_7_0};
      for (int k = 0; k < 2; k++) begin
        per = 255 * pre[k];
        if (rst) begin
          eo[k] = '0; ep[k] = 1'b0; n[k] = 0; dsh[k] = 8'h00;
        end else begin
          c     = (n[k] / pre[k]) % 255;
          lvl   = (dsh[k] == 8'hFF) || (c < int'(dsh[k]));
          eo[k] = en_o & (~en_p | {16{lvl}});
          ep[k] = (n[k] > 0) && (n[k] % per == 0);
          n[k]++;
          if (n[k] % per == 0) dsh[k] = bus1.pwm_duty_cycle;
        end
      end
      @(posedge clk);
      @(negedge clk);
      chk("out_p1",  32'(bus1.out),           32'(eo[0]));
      chk("ps_p1",   32'(bus1.period_start),  32'(ep[0]));
      chk("out_p13", 32'(bus13.out),          32'(eo[1]));
      chk("ps_p13",  32'(bus13.period_start), 32'(ep[1]));
    end
  endtask

  // Always advances at least once, then waits for period_start on one DUT.
  task automatic wait_ps(input int which, input int bound, output int waited);
    logic ps;
    waited = 0;
    do begin
      step(1);
      waited++;
      ps = which ? bus13.period_start : bus1.period_start;
    end while (!ps && waited < bound);
    if (!ps) chk("ps_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_hi(input int len, output int hi);
    hi = 0;
    for (int i = 0; i < len; i++) begin
      hi += int'(bus1.out[0]);
      step(1);
    end
  endtask

  initial begin
    int w, h1, h2;
    set_in(16'h0000, 16'h0000, 8'h00);
    step(3);
    chk("rst_out", 32'(bus1.out), 32'd0);
    rst = 1'b0;

    // Static channels are unaffected by the duty value.
    set_in(16'h00FF, 16'h0000, 8'h37);
    step(3 * 255);
    chk("static", 32'(bus1.out), 32'h00FF);

    // Mid-run reset with full duty armed: first period after reset stays low.
    set_in(16'h0001, 16'h0001, 8'hFF);
    step(37);
    rst = 1'b1;
    step(2);
    chk("rst_mid", 32'(bus13.out), 32'd0);
    rst = 1'b0;
    count_hi(254, h1);
    chk("first_low", 32'(h1), 32'd0);

    set_in(16'h0001, 16'h0001, 8'h80);
    wait_ps(0, 600, w);
    count_hi(255, h1);
    chk("hi_50", 32'(h1), 32'd128);

    set_in(16'h0001, 16'h0001, 8'h00);
    wait_ps(0, 600, w);
    count_hi(255, h1);
    chk("hi_00", 32'(h1), 32'd0);

    set_in(16'h0001, 16'h0001, 8'hFF);
    wait_ps(0, 600, w);
    count_hi(510, h1);
    chk("hi_ff", 32'(h1), 32'd510);

    // Duty change at cnt=100 must wait for the next boundary.
    set_in(16'h0001, 16'h0001, 8'h40);
    wait_ps(0, 600, w);
    count_hi(100, h1);
    set_in(16'h0001, 16'h0001, 8'hC0);
    count_hi(155, h2);
    chk("hi_mid_old", 32'(h1 + h2), 32'd64);
    chk("ps_next", 32'(bus1.period_start), 32'd1);
    count_hi(255, h1);
    chk("hi_mid_new", 32'(h1), 32'd192);

    // en_out gates everything; measure the PRESCALE=13 period.
    set_in(16'h0000, 16'hFFFF, 8'hFF);
    wait_ps(1, 4000, w);
    chk("prec_out", 32'(bus13.out), 32'd0);
    wait_ps(1, 4000, w);
    chk("per13", 32'(w), 32'd3315);

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0)
        set_in(16'($urandom), 16'($urandom), bus1.pwm_duty_cycle);
      if ($urandom_range(0, 199) == 0)
        set_in({bus1.en_reg_out_15_8, bus1.en_reg_out_7_0},
               {bus1.en_reg_pwm_15_8, bus1.en_reg_pwm_7_0}, 8'($urandom));
      rst = ($urandom_range(0, 1999) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
